// File: rtl/seq_chk_pkg.sv
// Shared types and constants for the sequence repetition checker.
package seq_chk_pkg;

  typedef enum logic [1:0] {
    REP_CONSEC    = 2'd0,
    REP_GOTO      = 2'd1,
    REP_NONCONSEC = 2'd2
  } rep_mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] MODE_RSVD = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_rep_checker.sv
// Hardware checker for A ##1 B[rep MIN:MAX] ##1 C, one attempt at a time,
// with saturating pass/fail tallies.
module seq_rep_checker
  import seq_chk_pkg::*;
#(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TALLY_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dis,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_min,
  input  logic [CNT_W-1:0]   cfg_max,
  input  logic               a,
  input  logic               b,
  input  logic               c,
  output logic               busy,
  output logic               pass,
  output logic               fail,
  output logic               tmo,
  output logic               ign,
  output logic               cfg_err,
  output logic [TALLY_W-1:0] pass_cnt,
  output logic [TALLY_W-1:0] fail_cnt
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  state_e             state, state_nx;
  rep_mode_e          mode_q, mode_nx;
  logic [CNT_W-1:0]   min_q, min_nx, max_q, max_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc;
  logic [TMR_W-1:0]   timer, timer_nx;
  logic               prev_ok, prev_ok_nx;
  logic               busy_nx, pass_nx, fail_nx, tmo_nx, ign_nx;
  logic               miss;

  assign cfg_err = (cfg_mode == MODE_RSVD) || (cfg_min == '0) || (cfg_min > cfg_max);

  // Next-state and verdict logic; rule priority is dis, pass, mode update, timeout.
  always_comb begin
    state_nx   = state;
    mode_nx    = mode_q;
    min_nx     = min_q;
    max_nx     = max_q;
    cnt_nx     = cnt;
    timer_nx   = timer;
    prev_ok_nx = prev_ok;
    pass_nx    = 1'b0;
    fail_nx    = 1'b0;
    tmo_nx     = 1'b0;
    ign_nx     = 1'b0;
    miss       = 1'b0;
    cnt_inc    = cnt + CNT_W'(1);

    case (state)
      S_IDLE: begin
        if (a && cfg_err) begin
          ign_nx = 1'b1;
        end else if (a && !dis) begin
          mode_nx    = rep_mode_e'(cfg_mode);
          min_nx     = cfg_min;
          max_nx     = cfg_max;
          cnt_nx     = '0;
          timer_nx   = '0;
          prev_ok_nx = 1'b0;
          state_nx   = S_RUN;
        end
      end
      S_RUN: begin
        ign_nx   = a;
        timer_nx = timer + TMR_W'(1);
        if (dis) begin
          state_nx = S_IDLE;
        end else if (prev_ok && c) begin
          pass_nx  = 1'b1;
          state_nx = S_IDLE;
        end else begin
          if (b && (cnt < max_q)) begin
            cnt_nx     = cnt_inc;
            prev_ok_nx = (cnt_inc >= min_q);
          end else begin
            case (mode_q)
              REP_CONSEC: miss = 1'b1;
              REP_GOTO: begin
                // A missed C slot after the k-th B disqualifies until the next B.
                miss       = b;
                prev_ok_nx = 1'b0;
              end
              default: miss = b;
            endcase
          end
          if (miss) begin
            fail_nx = 1'b1;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            fail_nx = 1'b1;
            tmo_nx  = 1'b1;
          end
          if (fail_nx) begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase

    busy_nx = (state_nx == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      mode_q  <= REP_CONSEC;
      min_q   <= '0;
      max_q   <= '0;
      cnt     <= '0;
      timer   <= '0;
      prev_ok <= 1'b0;
      busy    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      tmo     <= 1'b0;
      ign     <= 1'b0;
    end else begin
      state   <= state_nx;
      mode_q  <= mode_nx;
      min_q   <= min_nx;
      max_q   <= max_nx;
      cnt     <= cnt_nx;
      timer   <= timer_nx;
      prev_ok <= prev_ok_nx;
      busy    <= busy_nx;
      pass    <= pass_nx;
      fail    <= fail_nx;
      tmo     <= tmo_nx;
      ign     <= ign_nx;
    end
  end

  // Tallies step on the same edge that raises the matching pulse.
  sat_counter #(.WIDTH(TALLY_W)) u_pass_tally (
    .clk (clk),
    .rst (rst),
    .inc (pass_nx),
    .q   (pass_cnt)
  );

  sat_counter #(.WIDTH(TALLY_W)) u_fail_tally (
    .clk (clk),
    .rst (rst),
    .inc (fail_nx),
    .q   (fail_cnt)
  );

endmodule

// File: doc/seq_rep_checker.md
Name: seq_rep_checker

Overview:
- Synthesizable, single-thread hardware checker for the property family `A ##1 B[rep MIN:MAX] ##1 C`.
- Three repetition modes: consecutive `[*]`, goto `[->]`, non-consecutive `[=]`.
- Sequences one attempt at a time from trigger to verdict, and keeps saturating pass/fail tallies.
- Used on-chip and in emulation, where simulator assertions are unavailable; bench results are cross-checked against equivalent SVA.

Parameters:
- CNT_W, 4, width of the repetition counter and of cfg_min/cfg_max.
- TIMEOUT, 64, maximum cycles in RUN before a forced fail; must be ≥ 2.
- TALLY_W, 16, width of the saturating pass/fail tallies.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- dis  in  1  disable; aborts the current attempt with no verdict (disable-iff equivalent).
- cfg_mode  in  2  0=consecutive, 1=goto, 2=non-consecutive, 3=reserved.
- cfg_min  in  CNT_W  minimum repetition count.
- cfg_max  in  CNT_W  maximum repetition count.
- a  in  1  trigger.
- b  in  1  repeated term.
- c  in  1  terminator.
- busy  out  1  attempt in progress.
- pass  out  1  one-cycle pulse, attempt matched.
- fail  out  1  one-cycle pulse, attempt failed.
- tmo  out  1  qualifies fail; high with fail when the cause is timeout.
- ign  out  1  one-cycle pulse, trigger dropped (busy, invalid cfg, or deciding edge).
- cfg_err  out  1  combinational; cfg_mode==3 or cfg_min==0 or cfg_min>cfg_max.
- pass_cnt  out  TALLY_W  saturating count of passes.
- fail_cnt  out  TALLY_W  saturating count of fails.

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE; busy/pass/fail/tmo/ign=0; tallies=0; cnt=0; timer=0.
- IDLE:
  - a==1, dis==0, cfg_err==0 at edge T: latch mode/min/max, cnt=0, timer=0, go to RUN. busy is high from T.
  - a==1 with cfg_err==1: pulse ign, stay IDLE.
- RUN: evaluation starts at edge T+1 (the ##1). Evaluate at each edge, first matching rule wins:
  1. dis==1: go to IDLE, no verdict, tallies unchanged.
  2. Pass check: prev_ok && c → pass, go to IDLE.
     - prev_ok is a register, set when cnt ∈ [min,max] at the previous edge in the form required by the mode.
  3. Mode update:
     - Consecutive:
       - b==1 && cnt<max: cnt++; prev_ok=(cnt+1 ≥ min).
       - Otherwise fail.
       - First evaluation edge with b==0 and no pass → fail.
     - Goto:
       - b==1 && cnt<max: cnt++; prev_ok=(cnt+1 ≥ min).
       - b==1 && cnt==max: fail.
       - b==0: prev_ok=0 (the C slot after the k-th B was missed), keep waiting.
     - Non-consecutive:
       - b==1 && cnt<max: cnt++; prev_ok=(cnt+1 ≥ min).
       - b==1 && cnt==max: fail.
       - b==0: prev_ok unchanged (sticky once in range).
  4. timer==TIMEOUT-1 with no verdict: fail with tmo=1.
- Counters:
  - timer increments on every RUN edge.
  - cnt never exceeds max. No wrap is possible because cnt<max is checked before increment.
- Verdict timing:
  - pass/fail are registered.
  - Each pulses exactly once, in the cycle after the deciding edge.
  - pass and fail are mutually exclusive.
- Trigger handling outside IDLE:
  - a==1 in RUN (including the deciding edge) pulses ign and starts nothing.
  - A new attempt may start at the edge after the pulse.
- Tallies:
  - Increment with their pulse and saturate at all-ones.
  - dis does not touch them; only rst clears them.
- Configuration:
  - cfg_* changes during RUN have no effect (latched at trigger).
- Reset mid-attempt: no pulse, all state cleared at that edge.

Decomposition:
- Package seq_chk_pkg:
  - rep_mode_e {REP_CONSEC, REP_GOTO, REP_NONCONSEC}.
  - state_e {S_IDLE, S_RUN}.
  - Constant MODE_RSVD=2'd3.
- Sub-module sat_counter (WIDTH, inc → q, saturating, sync active-low clear), instantiated twice for the tallies.

Test Plan:
1. Consecutive, min=2, max=3:
   - a@T, b@T+1..T+2, c@T+3 → pass@T+4, pass_cnt=1.
   - Repeat with b low @T+2 → fail@T+3, tmo=0.
2. Goto, min=2, max=2:
   - a@T, b@T+2, b@T+5, c@T+6 → pass@T+7.
   - Same but c@T+7 → still busy, then tmo fail @T+TIMEOUT+1.
3. Non-consecutive, min=2, max=3:
   - a@T, b@T+1, b@T+3, c@T+6 → pass@T+7.
   - Four b before any c → fail on the 4th b edge +1.
4. Collisions:
   - a high every cycle for 10 cycles, consecutive min=max=1, b=1, c@T+2 → pass@T+3; ign pulses on a during RUN.
   - Second attempt starts only after return to IDLE.
5. Control:
   - cfg_min=0 with a → ign, cfg_err=1, busy=0.
   - dis@T+2 mid-attempt → busy low next cycle, no pass/fail, tallies unchanged.
   - rst low mid-RUN → all outputs 0.
6. Saturation (TALLY_W=4): 20 passing attempts → pass_cnt=15 and holds.
